// File: rtl/menu_pkg.sv
// Shared types and constants for the menu screen compositor.
package menu_pkg;
  typedef enum logic [1:0] {NAV = 2'd0, CONFIRM = 2'd1, DONE = 2'd2} menu_state_t;

  localparam logic [23:0] DEF_COLOR_IDLE    = 24'hF4_63_05;
  localparam logic [23:0] DEF_COLOR_SEL     = 24'hFF_A0_40;
  localparam logic [23:0] DEF_COLOR_CONFIRM = 24'h40_FF_40;
  localparam logic [23:0] DEF_COLOR_GLYPH   = 24'hFF_FF_FF;
  localparam int          GLYPH_COL_W       = 10;
endpackage

// File: rtl/menu_button_sprite.sv
// One button's hit test: registered button-area hit and stepped arrow glyph hit.
module menu_button_sprite import menu_pkg::*; #(
  parameter int BTN_X       = 380,
  parameter int BTN_Y       = 300,
  parameter int BTN_W       = 200,
  parameter int BTN_H       = 100,
  parameter int GLYPH_STEPS = 4,
  parameter int GLYPH_H     = 60,
  parameter int GLYPH_DH    = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        hit_out,
  output logic        glyph_hit_out
);
  localparam logic [11:0] X0 = 12'(BTN_X);
  localparam logic [11:0] X1 = 12'(BTN_X + BTN_W);
  localparam logic [11:0] Y0 = 12'(BTN_Y);
  localparam logic [11:0] Y1 = 12'(BTN_Y + BTN_H);

  logic [11:0]            w_x, w_y;
  logic                   w_hit;
  logic [GLYPH_STEPS-1:0] w_col;

  assign w_x   = {1'b0, hcount_in};
  assign w_y   = {2'b0, vcount_in};
  assign w_hit = (w_x >= X0) && (w_x < X1) && (w_y >= Y0) && (w_y < Y1);

  // Columns shrink by GLYPH_DH each step and stay vertically centred.
  for (genvar k = 0; k < GLYPH_STEPS; k++) begin : g_col
    localparam int          HK  = GLYPH_H - k * GLYPH_DH;
    localparam int          CXB = BTN_X + BTN_W / 2 - 5 * GLYPH_STEPS + GLYPH_COL_W * k;
    localparam int          CYB = BTN_Y + (BTN_H - HK) / 2;
    localparam logic [11:0] CX0 = 12'(CXB);
    localparam logic [11:0] CX1 = 12'(CXB + GLYPH_COL_W);
    localparam logic [11:0] CY0 = 12'(CYB);
    localparam logic [11:0] CY1 = 12'(CYB + HK);
    assign w_col[k] = (w_x >= CX0) && (w_x < CX1) && (w_y >= CY0) && (w_y < CY1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_out       <= 1'b0;
      glyph_hit_out <= 1'b0;
    end else begin
      hit_out       <= w_hit;
      glyph_hit_out <= |w_col;
    end
  end
endmodule

// File: rtl/menu_display.sv
// Menu compositor: button column + arrow glyphs over a sprite, cursor/confirm FSM.
// Optional MENU_BLINK_EN makes the NAV cursor button blink every BLINK_FRAMES frames.
module menu_display import menu_pkg::*; #(
  parameter int          NUM_BUTTONS    = 3,
  parameter int          BTN_X          = 380,
  parameter int          BTN_Y0         = 300,
  parameter int          BTN_W          = 200,
  parameter int          BTN_H          = 100,
  parameter int          BTN_GAP        = 20,
  parameter int          GLYPH_STEPS    = 4,
  parameter int          GLYPH_H        = 60,
  parameter int          GLYPH_DH       = 15,
  parameter logic [23:0] COLOR_IDLE     = DEF_COLOR_IDLE,
  parameter logic [23:0] COLOR_SEL      = DEF_COLOR_SEL,
  parameter logic [23:0] COLOR_CONFIRM  = DEF_COLOR_CONFIRM,
  parameter logic [23:0] COLOR_GLYPH    = DEF_COLOR_GLYPH,
  parameter int          BLINK_FRAMES   = 30,
  parameter int          CONFIRM_FRAMES = 45,
  localparam int         IW             = $clog2(NUM_BUTTONS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic [23:0]   img_sprite_in,
  input  logic          new_frame_in,
  input  logic          up_in,
  input  logic          down_in,
  input  logic          select_in,
  input  logic          choice_ack_in,
  output logic [23:0]   display_out,
  output logic [IW-1:0] cursor_out,
  output logic [IW-1:0] choice_out,
  output logic          choice_valid_out
);
  localparam int          FW   = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_BUTTONS - 1);

  menu_state_t          r_state;
  logic [IW-1:0]        r_cursor, r_choice;
  logic                 r_valid;
  logic [FW-1:0]        r_frames;
  logic [23:0]          r_sprite, r_display;
  logic [NUM_BUTTONS-1:0] w_hit, w_glyph;
  logic [23:0]          w_sel_color, w_pix;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    menu_button_sprite #(
      .BTN_X(BTN_X), .BTN_Y(BTN_Y0 + i * (BTN_H + BTN_GAP)), .BTN_W(BTN_W), .BTN_H(BTN_H),
      .GLYPH_STEPS(GLYPH_STEPS), .GLYPH_H(GLYPH_H), .GLYPH_DH(GLYPH_DH)
    ) u_btn (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hit_out(w_hit[i]), .glyph_hit_out(w_glyph[i])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= NAV;
      r_cursor <= '0;
      r_choice <= '0;
      r_valid  <= 1'b0;
      r_frames <= '0;
    end else begin
      case (r_state)
        NAV: begin
          if (select_in) begin
            r_choice <= r_cursor;
            r_frames <= '0;
            r_state  <= CONFIRM;
          end else if (up_in && !down_in) begin
            r_cursor <= (r_cursor == '0) ? LAST : r_cursor - 1'b1;
          end else if (down_in && !up_in) begin
            r_cursor <= (r_cursor == LAST) ? '0 : r_cursor + 1'b1;
          end
        end
        CONFIRM: begin
          if (new_frame_in) begin
            if (r_frames == FW'(CONFIRM_FRAMES - 1)) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_frames <= r_frames + 1'b1;
            end
          end
        end
        DONE: begin
          if (choice_ack_in) begin
            r_state <= NAV;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= NAV;
      endcase
    end
  end

`ifdef MENU_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;

  // Phase restarts at COLOR_SEL on every cursor move and on return to NAV.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_state == DONE && choice_ack_in) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_state == NAV && !select_in) begin
      if (up_in ^ down_in) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (new_frame_in) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign w_sel_color = r_blink_on ? COLOR_SEL : COLOR_IDLE;
`else
  assign w_sel_color = COLOR_SEL;
`endif

  always_comb begin
    w_pix = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (w_hit[i]) begin
        if (r_state == NAV && r_cursor == IW'(i))      w_pix = w_sel_color;
        else if (r_state != NAV && r_choice == IW'(i)) w_pix = COLOR_CONFIRM;
        else                                           w_pix = COLOR_IDLE;
      end
    end
    if (|w_glyph)          w_pix = COLOR_GLYPH;
    if (r_sprite != 24'h0) w_pix = r_sprite;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sprite  <= '0;
      r_display <= '0;
    end else begin
      r_sprite  <= img_sprite_in;
      r_display <= w_pix;
    end
  end

  assign display_out      = r_display;
  assign cursor_out       = r_cursor;
  assign choice_out       = r_choice;
  assign choice_valid_out = r_valid;
endmodule
